// File: rtl/match_pipe_prog.sv
// Multi-channel matching delay pipe with run-time selectable tap (0..MAX_DELAY), stall, flush
// and reconfiguration that waits for the pipe to drain so no in-flight entry is lost or doubled.

module match_pipe_lane #(
    parameter int WIDTH        = 1,
    parameter int MAX_DELAY    = 8,
    parameter int ZERO_INVALID = 1,
    parameter int DW           = 4
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             en,
    input  logic [DW-1:0]    sel,
    input  logic             tap_valid,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [MAX_DELAY:1][WIDTH-1:0] stg;
    logic [WIDTH-1:0]              raw;

    // Data shifts on every enabled edge; qualification comes from the shared valid pipe.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            stg <= '0;
        end else if (en) begin
            stg[1] <= din;
            for (int k = 2; k <= MAX_DELAY; k++) stg[k] <= stg[k-1];
        end
    end

    always_comb begin
        raw = din;
        for (int k = 1; k <= MAX_DELAY; k++)
            if (sel == DW'(k)) raw = stg[k];
    end

    assign dout = (ZERO_INVALID != 0 && !tap_valid) ? '0 : raw;
endmodule

module match_pipe_prog #(
    parameter int WIDTH         = 1,
    parameter int NCHAN         = 1,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 1,
    parameter int ZERO_INVALID  = 1,
    localparam int DW           = $clog2(MAX_DELAY+1)
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [NCHAN*WIDTH-1:0] in_data,
    input  logic [DW-1:0]          delay_in,
    input  logic                   delay_load,
    output logic                   out_valid,
    output logic [NCHAN*WIDTH-1:0] out_data,
    output logic [DW-1:0]          delay_q,
    output logic                   cfg_pending,
    output logic [DW-1:0]          occupancy
);
    logic [MAX_DELAY:1] vld_pipe;
    logic [DW-1:0]      delay_req;
    logic [DW-1:0]      clamped;
    logic [DW-1:0]      req_val;
    logic               occ_inc, occ_dec, pipe_empty, req_live;

    assign clamped    = (delay_in > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay_in;
    assign occ_inc    = en & in_valid & ~flush;
    assign occ_dec    = en & vld_pipe[MAX_DELAY] & ~flush;
    // Safe to retarget only when nothing is in the stages and nothing enters this edge.
    assign pipe_empty = (occupancy == '0) && !occ_inc;
    assign req_live   = cfg_pending | delay_load;
    assign req_val    = delay_load ? clamped : delay_req;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= MAX_DELAY; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            case ({occ_inc, occ_dec})
                2'b10:   occupancy <= occupancy + DW'(1);
                2'b01:   occupancy <= occupancy - DW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            delay_req   <= DW'(DEFAULT_DELAY);
            delay_q     <= DW'(DEFAULT_DELAY);
            cfg_pending <= 1'b0;
        end else begin
            if (delay_load) delay_req <= clamped;
            if (req_live && pipe_empty) delay_q <= req_val;
            cfg_pending <= req_live && !pipe_empty;
        end
    end

    always_comb begin
        out_valid = in_valid;
        for (int k = 1; k <= MAX_DELAY; k++)
            if (delay_q == DW'(k)) out_valid = vld_pipe[k];
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_lane
        match_pipe_lane #(
            .WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .ZERO_INVALID(ZERO_INVALID), .DW(DW)
        ) u_lane (
            .clk      (clk),
            .reset_l  (reset_l),
            .en       (en),
            .sel      (delay_q),
            .tap_valid(out_valid),
            .din      (in_data[c*WIDTH +: WIDTH]),
            .dout     (out_data[c*WIDTH +: WIDTH])
        );
    end

    a_occ_ovf: assert property (@(posedge clk) disable iff (!reset_l)
        !(occ_inc && !occ_dec && occupancy == DW'(MAX_DELAY)));
    a_occ_unf: assert property (@(posedge clk) disable iff (!reset_l)
        !(occ_dec && !occ_inc && occupancy == '0));
endmodule

// File: tb/tb_match_pipe_prog.sv
// Directed bench for match_pipe_prog: 4 channels x 12 bits, 8 stages, default delay 1.

module tb_match_pipe_prog;
    localparam int W = 12, NC = 4, MD = 8, DW = 4;
    localparam int DB = W*NC;

    logic          clk = 1'b0;
    logic          reset_l, en, flush, in_valid, delay_load;
    logic [DB-1:0] in_data, out_data;
    logic [DW-1:0] delay_in, delay_q, occupancy;
    logic          out_valid, cfg_pending;

    int pass_cnt = 0;
    int total_cnt = 0;

    match_pipe_prog #(
        .WIDTH(W), .NCHAN(NC), .MAX_DELAY(MD), .DEFAULT_DELAY(1), .ZERO_INVALID(1)
    ) dut (
        .clk(clk), .reset_l(reset_l), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .delay_in(delay_in), .delay_load(delay_load),
        .out_valid(out_valid), .out_data(out_data), .delay_q(delay_q),
        .cfg_pending(cfg_pending), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int d);
        in_valid = 1'b0; flush = 1'b0; en = 1'b1;
        for (int i = 0; i < 30 && occupancy != '0; i++) cyc();
        total_cnt++;
        if (occupancy !== '0) $display("FAIL drain_timeout occupancy=%0d want 0", occupancy);
        else pass_cnt++;
        delay_load = 1'b1; delay_in = DW'(d);
        cyc();
        delay_load = 1'b0;
        total_cnt++;
        if (delay_q !== DW'(d) || cfg_pending !== 1'b0)
            $display("FAIL set_delay delay_q=%0d pend=%b want %0d/0", delay_q, cfg_pending, d);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; delay_load = 1'b0;
        in_data = '0; delay_in = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, out_data, occupancy, cfg_pending} !== '0 || delay_q !== 4'd1)
            $display("FAIL reset_state ov=%b od=%h occ=%0d pend=%b dq=%0d want 0/0/0/0/1",
                     out_valid, out_data, occupancy, cfg_pending, delay_q);
        else pass_cnt++;
        reset_l = 1'b1;
        cyc();
    endtask

    task automatic test_delay3_pulse();
        logic [DB-1:0] exp_d;
        set_delay(3);
        in_data = DB'(12'h0A5); in_valid = 1'b1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL pulse_t0 out_valid=%b want 0", out_valid);
        else pass_cnt++;
        cyc();
        in_valid = 1'b0;    // data held so an invalid tap still carries 0xA5
        for (int k = 1; k <= 5; k++) begin
            exp_d = (k == 3) ? DB'(12'h0A5) : '0;
            total_cnt++;
            if (out_valid !== (k == 3) || out_data !== exp_d)
                $display("FAIL pulse_t%0d ov=%b od=%h want %b/%h", k, out_valid, out_data, k == 3, exp_d);
            else pass_cnt++;
            cyc();
        end
    endtask

    task automatic test_delay0();
        set_delay(0);
        in_data = 48'h123456789ABC; in_valid = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 48'h123456789ABC)
            $display("FAIL delay0_pass ov=%b od=%h want 1/123456789abc", out_valid, out_data);
        else pass_cnt++;
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL delay0_idle ov=%b od=%h want 0/0", out_valid, out_data);
        else pass_cnt++;
    endtask

    task automatic test_delay_max();
        logic [DB-1:0] hist [100];
        logic [DB-1:0] exp_d;
        logic          exp_v;
        for (int i = 0; i < 100; i++) hist[i] = {$urandom, $urandom};
        set_delay(MD);
        for (int i = 0; i <= 108; i++) begin
            in_valid = (i < 100);
            in_data  = (i < 100) ? hist[i] : '0;
            #1;
            exp_v = (i >= 8 && i < 108);
            exp_d = '0;
            if (exp_v) exp_d = hist[i-8];
            total_cnt++;
            if (out_valid !== exp_v || out_data !== exp_d)
                $display("FAIL max_stream_%0d ov=%b od=%h want %b/%h", i, out_valid, out_data, exp_v, exp_d);
            else pass_cnt++;
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        int vin [13] = '{1,1,1,1,0,0,0,0,1,0,0,0,0};
        int din [13] = '{1,2,3,4,0,0,0,0,5,0,0,0,0};
        int ein [13] = '{1,1,1,1,0,0,0,0,1,1,1,1,1};
        int ev  [13] = '{0,0,0,1,1,1,1,1,1,1,1,1,0};
        int ed  [13] = '{0,0,0,1,2,2,2,2,2,3,4,5,0};
        set_delay(3);
        for (int s = 0; s < 13; s++) begin
            in_valid = vin[s][0]; in_data = DB'(din[s]); en = ein[s][0];
            #1;
            total_cnt++;
            if (out_valid !== ev[s][0] || out_data !== DB'(ed[s]))
                $display("FAIL stall_step%0d ov=%b od=%h want %0d/%0d", s, out_valid, out_data, ev[s], ed[s]);
            else pass_cnt++;
            if (s >= 4 && s <= 7) begin
                total_cnt++;
                if (occupancy !== 4'd4) $display("FAIL stall_occ%0d occ=%0d want 4", s, occupancy);
                else pass_cnt++;
            end
            cyc();
        end
        en = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_reconfig();
        set_delay(3);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DB'(i + 8'h11);
            cyc();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (occupancy !== 4'd4) $display("FAIL reconf_occ occ=%0d want 4", occupancy);
        else pass_cnt++;
        delay_load = 1'b1; delay_in = 4'd6;
        cyc();
        delay_load = 1'b0;
        total_cnt++;
        if (cfg_pending !== 1'b1 || delay_q !== 4'd3)
            $display("FAIL reconf_wait pend=%b dq=%0d want 1/3", cfg_pending, delay_q);
        else pass_cnt++;
        repeat (7) cyc();
        total_cnt++;
        if (occupancy !== '0 || cfg_pending !== 1'b1 || delay_q !== 4'd3)
            $display("FAIL reconf_drained occ=%0d pend=%b dq=%0d want 0/1/3", occupancy, cfg_pending, delay_q);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (cfg_pending !== 1'b0 || delay_q !== 4'd6)
            $display("FAIL reconf_apply pend=%b dq=%0d want 0/6", cfg_pending, delay_q);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = DB'(i + 1);
            cyc();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (occupancy !== 4'd5) $display("FAIL flush_occ5 occ=%0d want 5", occupancy);
        else pass_cnt++;
        delay_load = 1'b1; delay_in = 4'd12;
        cyc();
        delay_load = 1'b0;
        total_cnt++;
        if (cfg_pending !== 1'b1 || out_valid !== 1'b1 || out_data !== DB'(1))
            $display("FAIL flush_pre pend=%b ov=%b od=%h want 1/1/1", cfg_pending, out_valid, out_data);
        else pass_cnt++;
        flush = 1'b1; in_valid = 1'b1; in_data = DB'(12'h777);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== '0 || cfg_pending !== 1'b1 || delay_q !== 4'd6)
            $display("FAIL flush_post ov=%b occ=%0d pend=%b dq=%0d want 0/0/1/6",
                     out_valid, occupancy, cfg_pending, delay_q);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (delay_q !== 4'd8 || cfg_pending !== 1'b0 || occupancy !== '0)
            $display("FAIL flush_apply dq=%0d pend=%b occ=%0d want 8/0/0", delay_q, cfg_pending, occupancy);
        else pass_cnt++;
    endtask

    task automatic test_channels_reset();
        logic [DB-1:0] w [3];
        w[0] = {12'hABC, 12'h123, 12'h456, 12'h789};
        w[1] = {12'hFFF, 12'h000, 12'h5A5, 12'hA5A};
        w[2] = {12'h001, 12'h800, 12'h0F0, 12'hF0F};
        set_delay(2);
        for (int s = 0; s < 6; s++) begin
            in_valid = (s < 3); in_data = (s < 3) ? w[s] : '0;
            #1;
            if (s >= 2) begin
                total_cnt++;
                if (out_valid !== (s < 5) || out_data !== ((s < 5) ? w[s-2] : '0))
                    $display("FAIL chan_step%0d ov=%b od=%h", s, out_valid, out_data);
                else pass_cnt++;
            end
            cyc();
        end
        for (int s = 0; s < 2; s++) begin
            in_valid = 1'b1; in_data = w[s];
            cyc();
        end
        in_data = w[2];
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== w[0])
            $display("FAIL chan_prereset ov=%b od=%h want 1/%h", out_valid, out_data, w[0]);
        else pass_cnt++;
        in_valid = 1'b0;
        reset_l = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== '0 || delay_q !== 4'd1 || occupancy !== '0 || cfg_pending !== 1'b0)
            $display("FAIL async_reset ov=%b od=%h dq=%0d occ=%0d pend=%b want 0/0/1/0/0",
                     out_valid, out_data, delay_q, occupancy, cfg_pending);
        else pass_cnt++;
        cyc();
        reset_l = 1'b1;
        cyc();
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== '0 || delay_q !== 4'd1)
            $display("FAIL post_reset ov=%b occ=%0d dq=%0d want 0/0/1", out_valid, occupancy, delay_q);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_delay3_pulse();
        test_delay0();
        test_delay_max();
        test_stall();
        test_reconfig();
        test_flush();
        test_channels_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
